// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: shares the single udp_packet TX engine between two requesters.
// req0 carries camera line packets, req1 carries low-rate status/box-ack packets.
// Each packet is sequenced IDLE -> GRANT -> XFER -> GAP -> IDLE with round-robin
// arbitration, a trigger pulse, byte counting on udp_read_en, a timeout abort and
// a fixed inter-packet gap.
//
// Ports:
//   clk, rstn                  rgmii_clk domain clock, async active-low reset
//   connected                  link/ARP up; gates new grants only
//   reqN, reqN_index, reqN_len level request plus packet index/length (sampled at grant)
//   reqN_data                  payload byte from requester N
//   reqN_grant                 1-cycle grant pulse
//   reqN_read_en               udp_read_en routed to the current owner during XFER
//   udp_trig                   1-cycle packet start to udp_packet
//   udp_index, udp_len         latched index/length of the current owner
//   udp_read_en                tx_read_en from udp_packet
//   udp_data                   owner's byte during XFER, 0 otherwise
//   busy, owner                busy in every state but IDLE; owner 0=req0, 1=req1
//   timeout_err                1-cycle pulse on abort
module udp_tx_arbiter #(
  parameter int unsigned TIMEOUT = 65535,
  parameter int unsigned GAP     = 12,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             connected,
  input  logic             req0,
  input  logic [15:0]      req0_index,
  input  logic [CNT_W-1:0] req0_len,
  input  logic [7:0]       req0_data,
  output logic             req0_grant,
  output logic             req0_read_en,
  input  logic             req1,
  input  logic [15:0]      req1_index,
  input  logic [CNT_W-1:0] req1_len,
  input  logic [7:0]       req1_data,
  output logic             req1_grant,
  output logic             req1_read_en,
  output logic             udp_trig,
  output logic [15:0]      udp_index,
  output logic [CNT_W-1:0] udp_len,
  input  logic             udp_read_en,
  output logic [7:0]       udp_data,
  output logic             busy,
  output logic             owner,
  output logic             timeout_err
);

  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ToLast  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GapLast = CNT_W'(GAP - 1);

  typedef enum logic [1:0] {StIdle, StGrant, StXfer, StGap} state_e;

  state_e           state_q;
  logic             last_owner_q;
  logic [CNT_W-1:0] byte_cnt_q;
  logic [CNT_W-1:0] to_cnt_q;
  logic [CNT_W-1:0] gap_cnt_q;

  logic             pick1;
  logic [15:0]      sel_index;
  logic [CNT_W-1:0] sel_len;
  logic             in_xfer;
  logic             last_byte;
  logic             to_hit;

  always_comb begin
    pick1 = req1;
    // Tie: the requester that did not own TX last time wins.
    if (req0 && req1) begin
      pick1 = ~last_owner_q;
    end
    sel_index = pick1 ? req1_index : req0_index;
    sel_len   = pick1 ? req1_len : req0_len;
    in_xfer   = (state_q == StXfer);
    last_byte = in_xfer && udp_read_en && (byte_cnt_q == udp_len - CntOne);
    to_hit    = in_xfer && (to_cnt_q == ToLast);
  end

  assign busy         = (state_q != StIdle);
  assign req0_read_en = in_xfer && !owner && udp_read_en;
  assign req1_read_en = in_xfer && owner && udp_read_en;
  assign udp_data     = in_xfer ? (owner ? req1_data : req0_data) : 8'h00;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      last_owner_q <= 1'b1;
      byte_cnt_q   <= '0;
      to_cnt_q     <= '0;
      gap_cnt_q    <= '0;
      req0_grant   <= 1'b0;
      req1_grant   <= 1'b0;
      udp_trig     <= 1'b0;
      udp_index    <= '0;
      udp_len      <= '0;
      owner        <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      req0_grant  <= 1'b0;
      req1_grant  <= 1'b0;
      udp_trig    <= 1'b0;
      timeout_err <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (connected && (req0 || req1)) begin
            // Grant/trig are registered so they are high during the GRANT cycle.
            state_q      <= StGrant;
            req0_grant   <= ~pick1;
            req1_grant   <= pick1;
            udp_trig     <= (sel_len != '0);
            owner        <= pick1;
            last_owner_q <= pick1;
            udp_index    <= sel_index;
            udp_len      <= sel_len;
          end
        end
        StGrant: begin
          byte_cnt_q <= '0;
          to_cnt_q   <= '0;
          gap_cnt_q  <= '0;
          state_q    <= (udp_len != '0) ? StXfer : StGap;
        end
        StXfer: begin
          to_cnt_q <= to_cnt_q + CntOne;
          if (udp_read_en) begin
            byte_cnt_q <= byte_cnt_q + CntOne;
          end
          // Last byte wins over a simultaneous timeout.
          if (last_byte) begin
            gap_cnt_q <= '0;
            state_q   <= StGap;
          end else if (to_hit) begin
            timeout_err <= 1'b1;
            gap_cnt_q   <= '0;
            state_q     <= StGap;
          end
        end
        StGap: begin
          if (gap_cnt_q == GapLast) begin
            state_q <= StIdle;
          end else begin
            gap_cnt_q <= gap_cnt_q + CntOne;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Randomized bench for udp_tx_arbiter with a transaction-level reference model:
// predicts the winner from round-robin history and the packet duration from
// the read_en stream it drives (bytes left, cycles spent, timeout budget).
module tb_udp_tx_arbiter;

  localparam int unsigned Timeout = 2000;
  localparam int unsigned Gap     = 12;
  localparam int unsigned CntW    = 16;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            connected = 1'b1;
  logic            req0 = 1'b0, req1 = 1'b0;
  logic [15:0]     req0_index = '0, req1_index = '0;
  logic [CntW-1:0] req0_len = '0, req1_len = '0;
  logic [7:0]      req0_data = '0, req1_data = '0;
  logic            req0_grant, req0_read_en, req1_grant, req1_read_en;
  logic            udp_trig;
  logic [15:0]     udp_index;
  logic [CntW-1:0] udp_len;
  logic            udp_read_en = 1'b0;
  logic [7:0]      udp_data;
  logic            busy, owner, timeout_err;

  int n_tests = 0;
  int n_fail  = 0;
  bit last_owner_m = 1'b1;
  bit pend0 = 1'b0, pend1 = 1'b0;

  udp_tx_arbiter #(
    .TIMEOUT(Timeout),
    .GAP    (Gap),
    .CNT_W  (CntW)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .connected   (connected),
    .req0        (req0),
    .req0_index  (req0_index),
    .req0_len    (req0_len),
    .req0_data   (req0_data),
    .req0_grant  (req0_grant),
    .req0_read_en(req0_read_en),
    .req1        (req1),
    .req1_index  (req1_index),
    .req1_len    (req1_len),
    .req1_data   (req1_data),
    .req1_grant  (req1_grant),
    .req1_read_en(req1_read_en),
    .udp_trig    (udp_trig),
    .udp_index   (udp_index),
    .udp_len     (udp_len),
    .udp_read_en (udp_read_en),
    .udp_data    (udp_data),
    .busy        (busy),
    .owner       (owner),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 32'({req0_grant, req1_grant, req0_read_en, req1_read_en,
                               udp_trig, busy, owner, timeout_err}), 32'd0);
    check({tag, "_idx"}, 32'(udp_index), 32'd0);
    check({tag, "_len"}, 32'(udp_len), 32'd0);
    check({tag, "_data"}, 32'(udp_data), 32'd0);
  endtask

  // Entered #1 after the edge that moved the DUT into GRANT; returns #1 into IDLE.
  task automatic run_packet(input bit who, input logic [15:0] idx, input logic [15:0] len,
                            input int p_rd);
    int  remaining;
    int  cycles;
    bit  timed_out;
    bit  rd;
    check("grant", 32'({req0_grant, req1_grant}), who ? 32'd1 : 32'd2);
    check("trig", 32'(udp_trig), 32'(len != 0));
    check("index", 32'(udp_index), 32'(idx));
    check("len", 32'(udp_len), 32'(len));
    check("owner", 32'({busy, owner}), 32'({1'b1, who}));
    if (who) begin
      req1 = 1'b0; pend1 = 1'b0;
    end else begin
      req0 = 1'b0; pend0 = 1'b0;
    end
    udp_read_en = 1'($urandom);
    #1;
    check("grant_noroute", 32'({req0_read_en, req1_read_en, udp_data}), 32'd0);
    remaining = int'(len);
    cycles    = 0;
    timed_out = 1'b0;
    if (len != 0) begin
      while (1) begin
        tick();
        check("xfer_ctl", 32'({busy, req0_grant, req1_grant, udp_trig, timeout_err}),
              32'b10000);
        connected   = 1'($urandom);
        rd          = (p_rd != 0) && ($urandom_range(3, 0) < p_rd);
        udp_read_en = rd;
        req0_data   = 8'($urandom);
        req1_data   = 8'($urandom);
        #1;
        check("xfer_route", 32'({req0_read_en, req1_read_en}),
              who ? 32'({1'b0, rd}) : 32'({rd, 1'b0}));
        check("xfer_data", 32'(udp_data), who ? 32'(req1_data) : 32'(req0_data));
        cycles++;
        if (rd) remaining--;
        if (remaining == 0) break;
        if (cycles == int'(Timeout)) begin
          timed_out = 1'b1;
          break;
        end
      end
    end
    for (int g = 0; g < int'(Gap); g++) begin
      tick();
      check("gap_err", 32'(timeout_err), (g == 0) ? 32'(timed_out) : 32'd0);
      check("gap_busy", 32'({busy, owner}), 32'({1'b1, who}));
      udp_read_en = 1'($urandom);
      req0_data   = 8'($urandom);
      req1_data   = 8'($urandom);
      #1;
      check("gap_noroute", 32'({req0_read_en, req1_read_en, udp_data}), 32'd0);
    end
    tick();
    check("gap_end_busy", 32'(busy), 32'd0);
    connected    = 1'b1;
    udp_read_en  = 1'b0;
    last_owner_m = who;
  endtask

  function automatic logic [15:0] rand_len();
    return ($urandom_range(7, 0) == 0) ? 16'd0 : 16'($urandom_range(40, 1));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          who;
    logic [15:0] idx, len;
    int          p_rd;

    tick();
    tick();
    check_all_zero("reset");
    rstn = 1'b1;
    tick();

    // Long line packet, continuous read_en.
    req0 = 1'b1; pend0 = 1'b1; req0_index = 16'h0005; req0_len = 16'd1280;
    tick();
    run_packet(1'b0, 16'h0005, 16'd1280, 4);

    // No grant while disconnected; grant right after connected rises.
    connected = 1'b0; req1 = 1'b1; pend1 = 1'b1; req1_index = 16'h00a1; req1_len = 16'd3;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("disc_nogrant", 32'({req1_grant, busy}), 32'd0);
    end
    connected = 1'b1;
    tick();
    run_packet(1'b1, 16'h00a1, 16'd3, 4);

    // Zero-length status packet.
    req1 = 1'b1; pend1 = 1'b1; req1_index = 16'h0b0b; req1_len = 16'd0;
    tick();
    run_packet(1'b1, 16'h0b0b, 16'd0, 4);

    // Randomized traffic with round-robin, partial read_en and occasional stuck-low.
    for (int t = 0; t < 120; t++) begin
      if (t == 0) begin
        pend0 = 1'b1; pend1 = 1'b1;
      end else begin
        if ($urandom_range(1, 0) == 1) pend0 = 1'b1;
        if ($urandom_range(1, 0) == 1) pend1 = 1'b1;
        if (!pend0 && !pend1) pend0 = 1'b1;
      end
      req0_index = 16'($urandom); req1_index = 16'($urandom);
      req0_len   = rand_len();    req1_len   = rand_len();
      req0 = pend0; req1 = pend1;
      who  = (pend0 && pend1) ? !last_owner_m : pend1;
      idx  = who ? req1_index : req0_index;
      len  = who ? req1_len : req0_len;
      p_rd = (t % 30 == 7) ? 0 : int'($urandom_range(4, 1));
      tick();
      run_packet(who, idx, len, p_rd);
    end
    if (pend0 || pend1) begin
      req0 = pend0; req1 = pend1;
      who  = (pend0 && pend1) ? !last_owner_m : pend1;
      tick();
      run_packet(who, who ? req1_index : req0_index, who ? req1_len : req0_len, 4);
    end

    // Reset in the middle of a transfer, then both request: req0 must win the tie.
    req0 = 1'b1; req0_index = 16'h0007; req0_len = 16'd1280;
    tick();
    check("rst_pre_grant", 32'(req0_grant), 32'd1);
    req0 = 1'b0;
    udp_read_en = 1'b1;
    for (int i = 0; i < 501; i++) tick();
    check("rst_pre_busy", 32'({busy, req0_read_en}), 32'd3);
    #2;
    rstn = 1'b0;
    #1;
    check_all_zero("midrst");
    req0 = 1'b1; pend0 = 1'b1;
    req1 = 1'b1; pend1 = 1'b1; req1_index = 16'h0c0c; req1_len = 16'd5;
    last_owner_m = 1'b1;
    #1;
    rstn = 1'b1;
    tick();
    run_packet(1'b0, 16'h0007, 16'd1280, 4);
    tick();
    run_packet(1'b1, 16'h0c0c, 16'd5, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
